// File: rtl/branch_pkg.sv
// Shared constants for the branch predictor and the branch-flush unit.
// No logic; counter-state encodings and recovery-PC select encodings.
// No flow control.
package branch_pkg;

  // 2-bit saturating counter states; MSB is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Recovery PC select seen by the flush unit
  localparam logic [1:0] PC_NORMAL   = 2'd0;
  localparam logic [1:0] PC_FALLTHRU = 2'd1;
  localparam logic [1:0] PC_TARGET   = 2'd2;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: step toward taken or not-taken.
// Purely combinational, zero latency.
// No flow control.
module sat_counter2
  import branch_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  // Step up on taken, down on not-taken, clamping at the strong states
  always_comb begin
    next = state;
    if (taken) begin
      if (state != ST) next = state + 2'd1;
    end else begin
      if (state != SNT) next = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: predicts in ID, resolves and trains in EX.
// Prediction is same-cycle; mispredict flag one edge after the branch leaves ID.
// No backpressure: a load-use stall or a mispredict turns the ID branch into a bubble.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        ID_branch_i,
  input  logic [31:0] ID_pc_i,
  input  logic        EX_taken_i,
  output logic        predict_o,
  output logic        predictWrong_o,
  output logic [1:0]  pcChoice_o,
  output logic [31:0] brCount_o,
  output logic [31:0] missCount_o
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       cnt_tbl [ENTRIES];
  logic [IDX_W-1:0] id_idx;
  logic             ex_valid;
  logic             ex_pred;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       upd_next;

  // Word-aligned PC bits above the index do not take part in the lookup
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ID_pc_i[31:IDX_W+2], ID_pc_i[1:0]};

  assign id_idx = ID_pc_i[IDX_W+1:2];

  // ID lookup: counter MSB, gated by the branch flag; reads pre-update value
  assign predict_o = ID_branch_i & cnt_tbl[id_idx][1];

  // EX resolve: compare the carried prediction with the real outcome
  assign predictWrong_o = ex_valid & (ex_pred != EX_taken_i);

  // Recovery select: predicted taken -> fall-through, predicted not-taken -> target
  always_comb begin
    pcChoice_o = PC_NORMAL;
    if (predictWrong_o) pcChoice_o = ex_pred ? PC_FALLTHRU : PC_TARGET;
  end

  sat_counter2 u_sat (
    .state (cnt_tbl[ex_idx]),
    .taken (EX_taken_i),
    .next  (upd_next)
  );

  // ID->EX register; a stall or a mispredict in EX squashes the ID branch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid <= 1'b0;
      ex_pred  <= 1'b0;
      ex_idx   <= '0;
    end else begin
      ex_valid <= ID_branch_i & ~stall_i & ~predictWrong_o;
      ex_pred  <= predict_o;
      ex_idx   <= id_idx;
    end
  end

  // Counter table training from the resolved EX branch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) cnt_tbl[i] <= INIT_STATE;
    end else if (ex_valid) begin
      cnt_tbl[ex_idx] <= upd_next;
    end
  end

  // Resolved-branch and misprediction statistics, wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      brCount_o   <= '0;
      missCount_o <= '0;
    end else begin
      if (ex_valid)       brCount_o   <= brCount_o + 32'd1;
      if (predictWrong_o) missCount_o <= missCount_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue-based scoreboard.
// Driver pushes the expected output set per cycle; monitor pops at negedge.
// Async-reset checks are requested explicitly through an event.
module tb_branch_predictor;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        ID_branch_i;
  logic [31:0] ID_pc_i;
  logic        EX_taken_i;
  logic        predict_o;
  logic        predictWrong_o;
  logic [1:0]  pcChoice_o;
  logic [31:0] brCount_o;
  logic [31:0] missCount_o;

  branch_predictor #(.IDX_W(4), .INIT_STATE(2'b11)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .ID_branch_i    (ID_branch_i),
    .ID_pc_i        (ID_pc_i),
    .EX_taken_i     (EX_taken_i),
    .predict_o      (predict_o),
    .predictWrong_o (predictWrong_o),
    .pcChoice_o     (pcChoice_o),
    .brCount_o      (brCount_o),
    .missCount_o    (missCount_o)
  );

  typedef struct {
    string       name;
    logic        pred;
    logic        wrong;
    logic [1:0]  pcc;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  event chk_ev;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s.%s: got %0h, expected %0h", n, f, act, req);
    end
  endtask

  // Monitor: compare whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        cmp(e.name, "predict",   {31'd0, predict_o},      {31'd0, e.pred});
        cmp(e.name, "wrong",     {31'd0, predictWrong_o}, {31'd0, e.wrong});
        cmp(e.name, "pcChoice",  {30'd0, pcChoice_o},     {30'd0, e.pcc});
        cmp(e.name, "brCount",   brCount_o,               e.br);
        cmp(e.name, "missCount", missCount_o,             e.miss);
      end
    end
  end

  task automatic push(input string n, input logic p, input logic w, input logic [1:0] c,
                      input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    e.name = n; e.pred = p; e.wrong = w; e.pcc = c; e.br = b; e.miss = m;
    exp_q.push_back(e);
  endtask

  // One cycle: drive just after the rising edge, queue the expectation
  task automatic cyc(input string n, input logic rst, input logic br, input logic [31:0] pc,
                     input logic stall, input logic tk,
                     input logic p, input logic w, input logic [1:0] c,
                     input logic [31:0] b, input logic [31:0] m);
    @(posedge clk_i);
    #1;
    rst_i = rst; ID_branch_i = br; ID_pc_i = pc; stall_i = stall; EX_taken_i = tk;
    push(n, p, w, c, b, m);
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; ID_branch_i = 1'b0; ID_pc_i = 32'h0; EX_taken_i = 1'b0;

    //  name        rst br pc     stl tk   pred wr pcc br miss
    cyc("reset",      0, 1, 32'h10, 0, 0,   1, 0, 0, 0, 0);
    cyc("first_id",   1, 1, 32'h10, 0, 0,   1, 0, 0, 0, 0);
    cyc("first_ex",   1, 0, 32'h00, 0, 1,   0, 0, 0, 0, 0);
    cyc("nt1_id",     1, 1, 32'h10, 0, 0,   1, 0, 0, 1, 0);
    cyc("nt1_ex",     1, 0, 32'h00, 0, 0,   0, 1, 1, 1, 0);
    cyc("nt2_id",     1, 1, 32'h10, 0, 0,   1, 0, 0, 2, 1);
    cyc("nt2_ex",     1, 0, 32'h00, 0, 0,   0, 1, 1, 2, 1);
    cyc("nt3_id",     1, 1, 32'h10, 0, 0,   0, 0, 0, 3, 2);
    cyc("nt3_ex",     1, 0, 32'h00, 0, 0,   0, 0, 0, 3, 2);
    cyc("sat_id",     1, 1, 32'h10, 0, 0,   0, 0, 0, 4, 2);
    cyc("sq_ex",      1, 1, 32'h10, 0, 1,   0, 1, 2, 4, 2);
    cyc("sq_none",    1, 0, 32'h00, 0, 1,   0, 0, 0, 5, 3);
    cyc("sq_cnt",     1, 0, 32'h00, 0, 0,   0, 0, 0, 5, 3);
    cyc("stall_id",   1, 1, 32'h10, 1, 0,   0, 0, 0, 5, 3);
    cyc("stall_rel",  1, 1, 32'h10, 0, 0,   0, 0, 0, 5, 3);
    cyc("stall_ex",   1, 0, 32'h00, 0, 0,   0, 0, 0, 5, 3);
    cyc("stall_cnt",  1, 0, 32'h00, 0, 0,   0, 0, 0, 6, 3);
    cyc("al_id0",     1, 1, 32'h10, 0, 0,   0, 0, 0, 6, 3);
    cyc("al_ex0",     1, 0, 32'h00, 0, 1,   0, 1, 2, 6, 3);
    cyc("al_id1",     1, 1, 32'h10, 0, 0,   0, 0, 0, 7, 4);
    cyc("alias_old",  1, 1, 32'h50, 0, 1,   0, 1, 2, 7, 4);
    cyc("alias_new",  1, 1, 32'h50, 0, 0,   1, 0, 0, 8, 5);
    cyc("pend_miss",  1, 0, 32'h00, 0, 0,   0, 1, 1, 8, 5);

    // Asynchronous reset while the mispredict is still pending in EX
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0, 0);
    ->chk_ev;

    // After reset, a single not-taken leaves 11->10 (still predicts taken)
    cyc("post_id",    1, 1, 32'h10, 0, 0,   1, 0, 0, 0, 0);
    cyc("post_ex",    1, 0, 32'h00, 0, 0,   0, 1, 1, 0, 0);
    cyc("post_look",  1, 1, 32'h10, 0, 0,   1, 0, 0, 1, 1);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
